reg_file: RTL and testbench

//  Operand register file directly upstream of the ALU in the single-cycle CPU.

---
 rtl/reg_file_if.sv | 26 ++
 rtl/reg_file.sv | 73 +++++++
 tb/tb_reg_file.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/reg_file_if.sv
// Operand register file bus: three read ports and one write port.
// master drives addresses and write data; slave returns read data.
interface reg_file_if #(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 5
);
   logic [ADDR_W-1:0] ra0;
   logic [WIDTH-1:0]  rd0;
   logic [ADDR_W-1:0] ra1;
   logic [WIDTH-1:0]  rd1;
   logic [ADDR_W-1:0] ra2;
   logic [WIDTH-1:0]  rd2;
   logic              we;
   logic [ADDR_W-1:0] wa;
   logic [WIDTH-1:0]  wd;

   modport master (
      output ra0, ra1, ra2, we, wa, wd,
      input  rd0, rd1, rd2
   );

   modport slave (
      input  ra0, ra1, ra2, we, wa, wd,
      output rd0, rd1, rd2
   );
endinterface

// File: rtl/reg_file.sv
// ALU operand register file: x0 hardwired to zero, write-first reads,
// third read port for the debug unit, synchronous active-high reset.
module reg_file #(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 5
) (
   input logic       clk,
   input logic       rst,
   reg_file_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_W;

   logic [WIDTH-1:0] regs_q [DEPTH];
   logic [WIDTH-1:0] regs_d [DEPTH];

   // Read mux for one port: zero reg, reset blanking, bypass, storage.
   function automatic logic [WIDTH-1:0] rd_sel(
      input logic [ADDR_W-1:0] ra,
      input logic [WIDTH-1:0]  stored,
      input logic              rst_v,
      input logic              we_v,
      input logic [ADDR_W-1:0] wa_v,
      input logic [WIDTH-1:0]  wd_v
   );
      logic [WIDTH-1:0] r;
      r = stored;
      if (ra == '0 || rst_v) begin
         r = '0;
      end else if (we_v && wa_v == ra) begin
         r = wd_v;
      end
      return r;
   endfunction

   // Next-state storage: apply the write, never touching x0.
   always_comb begin
      regs_d = regs_q;
      if (bus.we && bus.wa != '0) begin
         regs_d[bus.wa] = bus.wd;
      end
   end

   // Storage update; reset clears everything and drops the pending write.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   // Port 0: ALU operand a.
   always_comb begin
      bus.rd0 = rd_sel(bus.ra0, regs_q[bus.ra0],
                       rst, bus.we, bus.wa, bus.wd);
   end

   // Port 1: ALU operand b.
   always_comb begin
      bus.rd1 = rd_sel(bus.ra1, regs_q[bus.ra1],
                       rst, bus.we, bus.wa, bus.wd);
   end

   // Port 2: debug view, same bypass so it matches the ALU.
   always_comb begin
      bus.rd2 = rd_sel(bus.ra2, regs_q[bus.ra2],
                       rst, bus.we, bus.wa, bus.wd);
   end
endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: directed scenarios then random traffic,
// checked against an array model of the register contents.
module tb_reg_file;
   localparam int WIDTH  = 32;
   localparam int ADDR_W = 5;

   logic clk;
   logic rst;

   reg_file_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

   reg_file #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [WIDTH-1:0] model [32];
   int passed;
   int total;
   logic [WIDTH-1:0] got0;
   logic [WIDTH-1:0] got1;

   // Expected read value from the model for the current inputs.
   function automatic logic [WIDTH-1:0] expect_rd(
      input logic [ADDR_W-1:0] ra,
      input logic              r,
      input logic              w,
      input logic [ADDR_W-1:0] a,
      input logic [WIDTH-1:0]  d
   );
      if (r) return '0;
      if (ra == 0) return '0;
      if (w && a == ra) return d;
      return model[ra];
   endfunction

   task automatic check(input string tag,
                        input logic [WIDTH-1:0] obs,
                        input logic [WIDTH-1:0] exp_v);
      total++;
      assert (obs === exp_v) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
   endtask

   // One clock cycle: drive, check combinational reads, clock, update model.
   task automatic step(input logic r,
                       input logic w,
                       input logic [ADDR_W-1:0] a,
                       input logic [WIDTH-1:0] d,
                       input logic [ADDR_W-1:0] r0,
                       input logic [ADDR_W-1:0] r1,
                       input logic [ADDR_W-1:0] r2,
                       input string tag);
      rst     = r;
      bus.we  = w;
      bus.wa  = a;
      bus.wd  = d;
      bus.ra0 = r0;
      bus.ra1 = r1;
      bus.ra2 = r2;
      #2;
      got0 = bus.rd0;
      got1 = bus.rd1;
      check({tag, ".rd0"}, bus.rd0, expect_rd(r0, r, w, a, d));
      check({tag, ".rd1"}, bus.rd1, expect_rd(r1, r, w, a, d));
      check({tag, ".rd2"}, bus.rd2, expect_rd(r2, r, w, a, d));
      @(posedge clk);
      if (r) begin
         for (int i = 0; i < 32; i++) model[i] = '0;
      end else if (w && a != 0) begin
         model[a] = d;
      end
      #1;
   endtask

   initial begin
      logic [WIDTH-1:0] y;
      logic             cf;
      logic [ADDR_W-1:0] wa_r;
      passed = 0;
      total  = 0;
      for (int i = 0; i < 32; i++) model[i] = '0;
      rst = 1'b1;
      bus.we = 1'b0;
      bus.wa = '0;
      bus.wd = '0;
      bus.ra0 = '0;
      bus.ra1 = '0;
      bus.ra2 = '0;
      @(posedge clk);
      #1;

      // Reset pulse with a write that must be dropped.
      step(1, 1, 3, 32'hFFFF_FFFF, 3, 3, 3, "rst_pulse");
      for (int a = 0; a < 32; a++) begin
         step(0, 0, 0, 0, a[4:0], 5'(31 - a), a[4:0], "post_rst");
      end

      // Basic write/read.
      step(0, 1, 5, 32'h1234_5678, 0, 0, 0, "wr_x5");
      step(0, 1, 31, 32'hDEAD_BEEF, 0, 0, 0, "wr_x31");
      step(0, 0, 0, 0, 5, 31, 5, "rd_basic");
      check("basic.x5", got0, 32'h1234_5678);
      check("basic.x31", got1, 32'hDEAD_BEEF);

      // x0 hardwired.
      step(0, 1, 0, 32'hAAAA_AAAA, 0, 0, 0, "x0_wr");
      check("x0.same", got0, 32'h0);
      step(0, 0, 0, 0, 0, 0, 0, "x0_later");
      check("x0.later", got0, 32'h0);

      // Write-first bypass.
      step(0, 1, 7, 1, 0, 0, 0, "x7_init");
      step(0, 1, 7, 9, 7, 7, 7, "bypass");
      check("bypass.rd0", got0, 32'd9);
      step(0, 0, 0, 0, 7, 7, 7, "bypass_next");
      check("bypass_next.rd0", got0, 32'd9);

      // Reset mid-stream.
      step(0, 1, 2, 5, 0, 0, 0, "x2_init");
      step(1, 1, 2, 6, 2, 2, 2, "mid_rst");
      check("mid_rst.rd0", got0, 32'd0);
      step(0, 0, 0, 0, 2, 7, 5, "after_mid_rst");
      check("after_mid_rst.x2", got0, 32'd0);

      // ALU hookup: add of rd0/rd1, result written back to x3.
      step(0, 1, 1, 32'hFFFF_FFFF, 0, 0, 0, "x1_init");
      step(0, 1, 2, 1, 0, 0, 0, "x2_set");
      step(0, 0, 0, 0, 1, 2, 0, "alu_rd");
      {cf, y} = {1'b0, got0} + {1'b0, got1};
      check("alu.y", y, 32'd0);
      check("alu.cf", {31'd0, cf}, 32'd1);
      check("alu.zero", {31'd0, (y == 0)}, 32'd1);
      step(0, 1, 3, y, 0, 0, 0, "alu_wb");
      step(0, 0, 0, 0, 3, 1, 2, "alu_rdback");
      check("alu.x3", got0, 32'd0);

      // Random traffic.
      for (int n = 0; n < 400; n++) begin
         wa_r = 5'($urandom_range(0, 31));
         step(($urandom_range(0, 39) == 0),
              1'($urandom),
              wa_r,
              $urandom,
              ($urandom_range(0, 2) == 0) ? wa_r : 5'($urandom),
              ($urandom_range(0, 2) == 0) ? wa_r : 5'($urandom),
              ($urandom_range(0, 2) == 0) ? wa_r : 5'($urandom),
              "rand");
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
